can_ctrl_fifo: RTL and testbench

Parametrised CAN controller register block with a full 8-byte payload, a timed TX state machine, a loopback path into a depth-configurable RX FIFO, and an optional interrupt. It sits on the SoC Wishbone bus as a CPU-visible peripheral. It is the multi-frame, full-DLC generation of the single-frame loopback controller. There is no bus-level bit timing yet; TX completion is modelled by a programmable latency.

---
 rtl/can_ctrl_fifo.sv | 264 ++++++++++++++++++++++++++
 tb/tb_can_ctrl_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/can_ctrl_fifo.sv
// CAN controller register block: Wishbone CSRs, timed TX FSM, loopback into an RX FIFO.
// Optional interrupt logic and IRQ_EN register are built when CAN_CTRL_IRQ_EN is defined.
module can_ctrl_fifo #(
    parameter int RX_DEPTH = 4,
    parameter int TX_LAT   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        tx_busy,
    output logic        rx_not_empty,
    output logic        irq
);

    localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int LW = (TX_LAT > 1) ? $clog2(TX_LAT) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RX_DEPTH);
    localparam logic [LW-1:0] LAT_LOAD = LW'(TX_LAT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } tx_state_t;

    function automatic logic [3:0] clamp_dlc(input logic [3:0] dlc);
        return (dlc > 4'd8) ? 4'd8 : dlc;
    endfunction

    // Bytes at index >= dlc are forced to zero
    function automatic logic [63:0] mask_payload(input logic [63:0] data, input logic [3:0] dlc);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(dlc)) m[i*8 +: 8] = 8'hFF;
        end
        return data & m;
    endfunction

    logic        access, wr_en, rd_en;
    logic [3:0]  reg_sel;
    logic        wr_cmd, wr_status, wr_id, wr_dlc, wr_lo, wr_hi;
    logic        rx_pop;
    logic        unused_adr;

    logic        loopback_en;
    logic [10:0] tx_id;
    logic [3:0]  tx_dlc;
    logic [31:0] tx_lo, tx_hi;
    logic        tx_start_q;
    logic        tx_done, rx_ovf, tx_err;
`ifdef CAN_CTRL_IRQ_EN
    logic [2:0]  irq_en;
    logic        wr_irq_en;
`endif

    tx_state_t   state, state_nxt;
    logic [LW-1:0] lat_cnt;
    logic        snap_en, frame_done, start_err;
    logic [3:0]  tx_dlc_clamped;

    logic [10:0] sh_id;
    logic [3:0]  sh_dlc;
    logic [63:0] sh_data;
    logic        sh_loop;

    logic [10:0] fifo_id   [RX_DEPTH];
    logic [3:0]  fifo_dlc  [RX_DEPTH];
    logic [63:0] fifo_data [RX_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic        push_req, do_push, do_pop, ovf_set;

    logic [10:0] head_id;
    logic [3:0]  head_dlc;
    logic [63:0] head_data;
    logic [31:0] status_word;
    logic [31:0] rd_data;

    assign access     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_en      = access & wb_we_i;
    assign rd_en      = access & ~wb_we_i;
    assign reg_sel    = wb_adr_i[5:2];
    assign unused_adr = ^{wb_adr_i[31:6], wb_adr_i[1:0]};

    assign wr_cmd    = wr_en && (reg_sel == 4'd0);
    assign wr_status = wr_en && (reg_sel == 4'd1);
    assign wr_id     = wr_en && (reg_sel == 4'd2);
    assign wr_dlc    = wr_en && (reg_sel == 4'd3);
    assign wr_lo     = wr_en && (reg_sel == 4'd4);
    assign wr_hi     = wr_en && (reg_sel == 4'd5);
`ifdef CAN_CTRL_IRQ_EN
    assign wr_irq_en = wr_en && (reg_sel == 4'd10);
`endif

    // Pop acts in the access cycle so the head view moves on the same edge
    assign rx_pop = wr_cmd & wb_dat_i[2];

    // ---- Bus handshake and registered read data ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= access;
            if (rd_en) wb_dat_o <= rd_data;
        end
    end

    // ---- Control/configuration registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start_q  <= 1'b0;
            loopback_en <= 1'b0;
            tx_id       <= '0;
            tx_dlc      <= '0;
            tx_lo       <= '0;
            tx_hi       <= '0;
`ifdef CAN_CTRL_IRQ_EN
            irq_en      <= '0;
`endif
        end else begin
            tx_start_q <= wr_cmd & wb_dat_i[0];
            if (wr_cmd) loopback_en <= wb_dat_i[1];
            if (wr_id)  tx_id  <= wb_dat_i[10:0];
            if (wr_dlc) tx_dlc <= wb_dat_i[3:0];
            if (wr_lo)  tx_lo  <= wb_dat_i;
            if (wr_hi)  tx_hi  <= wb_dat_i;
`ifdef CAN_CTRL_IRQ_EN
            if (wr_irq_en) irq_en <= wb_dat_i[2:0];
`endif
        end
    end

    // ---- TX FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tx_start_q) state_nxt = BUSY;
            BUSY:    if (lat_cnt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_busy    = (state == BUSY);
        snap_en    = (state == IDLE) & tx_start_q;
        start_err  = (state == BUSY) & tx_start_q;
        frame_done = (state == BUSY) & (lat_cnt == '0);
    end

    assign tx_dlc_clamped = clamp_dlc(tx_dlc);

    // In-flight frame is frozen in shadow registers; later TX_* writes do not disturb it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt <= '0;
            sh_id   <= '0;
            sh_dlc  <= '0;
            sh_data <= '0;
            sh_loop <= 1'b0;
        end else if (snap_en) begin
            lat_cnt <= LAT_LOAD;
            sh_id   <= tx_id;
            sh_dlc  <= tx_dlc_clamped;
            sh_data <= mask_payload({tx_hi, tx_lo}, tx_dlc_clamped);
            sh_loop <= loopback_en;
        end else if (tx_busy && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - LW'(1);
        end
    end

    // ---- RX FIFO ----
    assign push_req = frame_done & sh_loop;
    assign do_pop   = rx_pop & (count != '0);
    assign do_push  = push_req & ((count != FULL_CNT) | do_pop);
    assign ovf_set  = push_req & ~do_push;

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_id[wr_ptr]   <= sh_id;
            fifo_dlc[wr_ptr]  <= sh_dlc;
            fifo_data[wr_ptr] <= sh_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rx_not_empty = (count != '0);
    assign head_id   = rx_not_empty ? fifo_id[rd_ptr]   : '0;
    assign head_dlc  = rx_not_empty ? fifo_dlc[rd_ptr]  : '0;
    assign head_data = rx_not_empty ? fifo_data[rd_ptr] : '0;

    // ---- Sticky status bits: a hardware set beats a same-cycle W1C ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_done <= 1'b0;
            rx_ovf  <= 1'b0;
            tx_err  <= 1'b0;
        end else begin
            tx_done <= frame_done | (tx_done & ~(wr_status & wb_dat_i[0]));
            rx_ovf  <= ovf_set    | (rx_ovf  & ~(wr_status & wb_dat_i[2]));
            tx_err  <= start_err  | (tx_err  & ~(wr_status & wb_dat_i[4]));
        end
    end

    assign status_word = {16'b0, 8'(count), 3'b0, tx_err, tx_busy, rx_ovf, rx_not_empty, tx_done};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            4'd0:  rd_data = {30'b0, loopback_en, 1'b0};
            4'd1:  rd_data = status_word;
            4'd2:  rd_data = {21'b0, tx_id};
            4'd3:  rd_data = {28'b0, tx_dlc};
            4'd4:  rd_data = tx_lo;
            4'd5:  rd_data = tx_hi;
            4'd6:  rd_data = {21'b0, head_id};
            4'd7:  rd_data = {28'b0, head_dlc};
            4'd8:  rd_data = head_data[31:0];
            4'd9:  rd_data = head_data[63:32];
`ifdef CAN_CTRL_IRQ_EN
            4'd10: rd_data = {29'b0, irq_en};
`endif
            default: rd_data = '0;
        endcase
    end

    // ---- Interrupt ----
`ifdef CAN_CTRL_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= |({rx_ovf, rx_not_empty, tx_done} & irq_en);
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_can_ctrl_fifo.sv
// Scoreboard bench for can_ctrl_fifo (RX_DEPTH=4, TX_LAT=8); reads are checked by a bus monitor.
module tb_can_ctrl_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
    logic        tx_busy, rx_not_empty, irq;

`ifdef CAN_CTRL_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_val_q[$];
    string       exp_name_q[$];
    logic        rd_flag = 1'b0;
    int          ack_len = 0;
    logic [31:0] mon_exp;
    string       mon_name;

    can_ctrl_fifo #(.RX_DEPTH(4), .TX_LAT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
        .tx_busy(tx_busy), .rx_not_empty(rx_not_empty), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: compares each read acknowledge against the scoreboard and checks ack width
    always @(negedge clk) begin
        if (wb_ack_o) begin
            ack_len++;
            if (rd_flag) begin
                checks++;
                if (exp_val_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: got %h, nothing expected", wb_dat_o);
                end else begin
                    mon_exp  = exp_val_q.pop_front();
                    mon_name = exp_name_q.pop_front();
                    if (wb_dat_o !== mon_exp) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h", mon_name, wb_dat_o, mon_exp);
                    end
                end
            end
        end else if (ack_len > 0) begin
            checks++;
            if (ack_len != 1) begin
                errors++;
                $display("FAIL ack_width: got %0d cycles expected 1", ack_len);
            end
            ack_len = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat);
        @(posedge clk); #1;
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; rd_flag = ~we;
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        wb_xfer(adr, 1'b1, dat);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string nm);
        exp_val_q.push_back(exp);
        exp_name_q.push_back(nm);
        wb_xfer(adr, 1'b0, 32'h0);
    endtask

    // Counts BUSY cycles of one frame; a stuck FSM exhausts the guard and fails the count
    task automatic wait_tx(input int exp_cyc, input string nm);
        int n = 0;
        int guard = 0;
        while (guard < 200) begin
            @(negedge clk);
            guard++;
            if (tx_busy) n++;
            else if (n > 0) break;
        end
        chk(nm, 32'(n), 32'(exp_cyc));
    endtask

    initial begin
        rst_n = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Reset state
        chk_bit("rst_ack", wb_ack_o, 1'b0);
        chk("rst_dat_o", wb_dat_o, 32'h0);
        chk_bit("rst_tx_busy", tx_busy, 1'b0);
        chk_bit("rst_rx_not_empty", rx_not_empty, 1'b0);
        chk_bit("rst_irq", irq, 1'b0);
        for (int a = 0; a < 12; a++) rd(32'(a * 4), 32'h0, $sformatf("rst_reg_%02h", a * 4));

        // Frame 1: DLC 3 with loopback; high bytes must be zeroed
        wr(32'h28, 32'h1);
        rd(32'h28, {31'b0, IRQ_ON}, "irq_en_rb");
        wr(32'h08, 32'h123);
        wr(32'h0C, 32'h3);
        wr(32'h10, 32'hDDCCBBAA);
        wr(32'h14, 32'h11223344);
        wr(32'h00, 32'h3);
        wait_tx(8, "f1_busy_cycles");
        chk_bit("f1_irq_same_cycle", irq, 1'b0);
        @(negedge clk);
        chk_bit("f1_irq_rise", irq, IRQ_ON);
        rd(32'h04, 32'h0000_0103, "f1_status");
        chk_bit("f1_rx_not_empty", rx_not_empty, 1'b1);
        rd(32'h00, 32'h2, "f1_cmd");
        rd(32'h18, 32'h123, "f1_rx_id");
        rd(32'h1C, 32'h3, "f1_rx_dlc");
        rd(32'h20, 32'h00CCBBAA, "f1_rx_lo");
        rd(32'h24, 32'h0, "f1_rx_hi");
        rd(32'h14, 32'h11223344, "f1_tx_hi");
        wr(32'h04, 32'h1);
        chk_bit("f1_irq_hold", irq, IRQ_ON);
        @(posedge clk); #1;
        chk_bit("f1_irq_fall", irq, 1'b0);
        rd(32'h04, 32'h0000_0102, "f1_status_w1c");
        wr(32'h00, 32'h6);
        rd(32'h04, 32'h0, "f1_status_pop");
        chk_bit("f1_rx_empty", rx_not_empty, 1'b0);
        rd(32'h18, 32'h0, "f1_rx_id_empty");

        // Frame 2: DLC 12 clamps to 8, all bytes kept
        wr(32'h08, 32'h7FF);
        wr(32'h0C, 32'hC);
        wr(32'h10, 32'h04030201);
        wr(32'h14, 32'h08070605);
        wr(32'h00, 32'h3);
        wait_tx(8, "f2_busy_cycles");
        rd(32'h18, 32'h7FF, "f2_rx_id");
        rd(32'h1C, 32'h8, "f2_rx_dlc");
        rd(32'h20, 32'h04030201, "f2_rx_lo");
        rd(32'h24, 32'h08070605, "f2_rx_hi");
        rd(32'h0C, 32'hC, "f2_tx_dlc");
        wr(32'h04, 32'h1);
        wr(32'h00, 32'h6);
        rd(32'h04, 32'h0, "f2_status");

        // Overflow: five DLC-0 frames into a 4-deep FIFO
        wr(32'h0C, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            wr(32'h08, 32'(i));
            wr(32'h00, 32'h3);
            wait_tx(8, $sformatf("ovf_busy_%0d", i));
        end
        rd(32'h04, 32'h0000_0407, "ovf_status");
        rd(32'h1C, 32'h0, "ovf_rx_dlc0");
        rd(32'h20, 32'h0, "ovf_rx_lo_masked");
        for (int i = 1; i <= 4; i++) begin
            rd(32'h18, 32'(i), $sformatf("ovf_head_%0d", i));
            wr(32'h00, 32'h6);
        end
        rd(32'h18, 32'h0, "ovf_head_empty");
        rd(32'h04, 32'h0000_0005, "ovf_status_empty");
        wr(32'h04, 32'h4);
        rd(32'h04, 32'h0000_0001, "ovf_clear");
        wr(32'h04, 32'h1);

        // Push and pop on the same edge: empty FIFO (pop ignored), then full FIFO
        wr(32'h08, 32'h0AA);
        wr(32'h00, 32'h3);
        repeat (7) @(posedge clk);
        wr(32'h00, 32'h6);
        rd(32'h04, 32'h0000_0103, "pp_empty_status");
        rd(32'h18, 32'h0AA, "pp_empty_head");
        for (int i = 1; i <= 3; i++) begin
            wr(32'h08, 32'(8'hB0 + i));
            wr(32'h00, 32'h3);
            wait_tx(8, $sformatf("pp_fill_%0d", i));
        end
        rd(32'h04, 32'h0000_0403, "pp_full_status");
        wr(32'h08, 32'h0C0);
        wr(32'h00, 32'h3);
        repeat (7) @(posedge clk);
        wr(32'h00, 32'h6);
        rd(32'h04, 32'h0000_0403, "pp_full_status_after");
        rd(32'h18, 32'h0B1, "pp_full_head");
        for (int i = 0; i < 3; i++) wr(32'h00, 32'h6);
        rd(32'h18, 32'h0C0, "pp_full_tail");
        wr(32'h00, 32'h4);
        wr(32'h04, 32'h1);
        rd(32'h04, 32'h0, "pp_drained");

        // TX_START while busy, and W1C racing the TX_DONE set
        wr(32'h00, 32'h1);
        wr(32'h00, 32'h1);
        repeat (5) @(posedge clk);
        wr(32'h04, 32'h1);
        rd(32'h04, 32'h0000_0011, "race_done_err");
        wr(32'h04, 32'h1);
        repeat (20) @(posedge clk);
        rd(32'h04, 32'h0000_0010, "race_single_done");
        wr(32'h04, 32'h10);
        rd(32'h04, 32'h0, "race_clear");

        // Reset in the middle of a loopback frame
        wr(32'h08, 32'h055);
        wr(32'h00, 32'h3);
        repeat (3) @(posedge clk); #1;
        chk_bit("mid_busy", tx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_bit("mid_rst_busy", tx_busy, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (15) @(posedge clk); #1;
        chk_bit("mid_no_push", rx_not_empty, 1'b0);
        rd(32'h04, 32'h0, "mid_status");
        rd(32'h00, 32'h0, "mid_cmd");
        rd(32'h08, 32'h0, "mid_tx_id");

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_val_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
